mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arb_pkg.sv | 20 ++
 rtl/mul_arbiter_if.sv | 32 +++
 rtl/mul_shift_core.sv | 58 +++++
 rtl/mul_arbiter.sv | 136 +++++++++++++
 tb/tb_mul_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mul_arb_pkg.sv
// Shared definitions for the shared-multiplier arbiter: FSM encoding,
// default operand width and the requester-id type.
package mul_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic req_id_t;

  // The requester that is not `id`; used when the grant pointer advances.
  function automatic req_id_t other_req(input req_id_t id);
    return ~id;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Bus between two operand requesters and the shared multiplier.
// master: requester/environment side; slave: the arbiter.
interface mul_arbiter_if #(
  parameter int WIDTH = mul_arb_pkg::DEFAULT_WIDTH
);
  logic               req0_valid;
  logic [WIDTH-1:0]   req0_a;
  logic [WIDTH-1:0]   req0_b;
  logic               req0_ready;
  logic               req1_valid;
  logic [WIDTH-1:0]   req1_a;
  logic [WIDTH-1:0]   req1_b;
  logic               req1_ready;
  logic               rsp_valid;
  logic               rsp_id;
  logic [2*WIDTH-1:0] rsp_product;
  logic               busy;

  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_product, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_product, busy
  );
endinterface

// File: rtl/mul_shift_core.sv
// Unsigned shift-add multiplier. `start` loads the operands and clears the
// accumulator; each `step` consumes one multiplier bit, LSB first. `done`
// flags the cycle whose step is the last one, so the product is final in
// the accumulator right after that edge.
module mul_shift_core
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               start,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // Accumulator and step counter: cleared on start, advanced on each step.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      acc <= '0;
      cnt <= '0;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Operand shift registers: multiplicand moves left, multiplier right.
  always_ff @(posedge clk) begin
    if (start) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (step) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign done    = step && (cnt == LAST_STEP);
  assign product = acc;

endmodule

// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of one shift-add multiplier.
// Optional feature macro: MUL_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; without it req0 has fixed priority.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          areset,
  mul_arbiter_if.slave  bus
);

  state_t             state;
  state_t             state_n;
  req_id_t            grant_id;
  req_id_t            id_q;
  logic               rdy0;
  logic               rdy1;
  logic               accept;
  logic               step;
  logic               core_done;
  logic [WIDTH-1:0]   op_a;
  logic [WIDTH-1:0]   op_b;
  logic [2*WIDTH-1:0] core_prod;
  logic [2*WIDTH-1:0] prod_q;

`ifdef MUL_ARB_ROUND_ROBIN_EN
  req_id_t ptr;

  // Grant pointer flips after every acceptance.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      ptr <= 1'b0;
    end else if (accept) begin
      ptr <= other_req(ptr);
    end
  end

  // Pointer decides a tie; a lone requester always wins.
  always_comb begin
    grant_id = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ptr;
    end else if (bus.req1_valid) begin
      grant_id = 1'b1;
    end
  end
`else
  // Fixed priority: req1 only when req0 is not asking.
  always_comb begin
    grant_id = (!bus.req0_valid && bus.req1_valid);
  end
`endif

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic and per-state handshake outputs.
  always_comb begin
    state_n = state;
    rdy0    = 1'b0;
    rdy1    = 1'b0;
    step    = 1'b0;
    case (state)
      IDLE: begin
        rdy0 = bus.req0_valid && (grant_id == 1'b0);
        rdy1 = bus.req1_valid && (grant_id == 1'b1);
        if (rdy0 || rdy1) begin
          state_n = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (core_done) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign accept = rdy0 || rdy1;
  assign op_a   = grant_id ? bus.req1_a : bus.req0_a;
  assign op_b   = grant_id ? bus.req1_b : bus.req0_b;

  // Owner of the operation in flight, captured at acceptance.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      id_q <= 1'b0;
    end else if (accept) begin
      id_q <= grant_id;
    end
  end

  // Last delivered product, held between responses.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      prod_q <= '0;
    end else if (state == DONE) begin
      prod_q <= core_prod;
    end
  end

  mul_shift_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk     (clk),
    .areset  (areset),
    .start   (accept),
    .step    (step),
    .a       (op_a),
    .b       (op_b),
    .done    (core_done),
    .product (core_prod)
  );

  assign bus.req0_ready  = rdy0;
  assign bus.req1_ready  = rdy1;
  assign bus.rsp_valid   = (state == DONE);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_product = (state == DONE) ? core_prod : prod_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with hand-computed expected values.
module tb_mul_arbiter;

  logic clk;
  logic areset;
  int   n_vec;
  int   n_err;
  int   cyc;

  mul_arbiter_if #(.WIDTH(8)) bus ();

  mul_arbiter #(
    .WIDTH (8)
  ) dut (
    .clk    (clk),
    .areset (areset),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a response; returns at #1 after the edge entering DONE.
  task automatic wait_rsp(output logic id, output logic [15:0] p,
                          output int c, output int lat);
    lat = 0;
    id  = 1'b0;
    p   = '0;
    c   = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) begin
        lat = k;
        id  = bus.rsp_id;
        p   = bus.rsp_product;
        c   = cyc;
        break;
      end
    end
    if (lat == 0) check_eq("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input bit who, input logic [7:0] a, input logic [7:0] b,
                        input logic [15:0] exp_p);
    logic        id;
    logic [15:0] p;
    int          c;
    int          lat;
    @(negedge clk);
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end
    #1;
    check_eq("ready0_idle", {31'd0, bus.req0_ready}, {31'd0, ~who});
    check_eq("ready1_idle", {31'd0, bus.req1_ready}, {31'd0, who});
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check_eq("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    wait_rsp(id, p, c, lat);
    check_eq("latency", lat, 32'd8);
    check_eq("rsp_id", {31'd0, id}, {31'd0, who});
    check_eq("rsp_product", {16'd0, p}, {16'd0, exp_p});
    @(posedge clk);
    #1;
    check_eq("rsp_valid_pulse", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("product_hold", {16'd0, bus.rsp_product}, {16'd0, exp_p});
    check_eq("busy_idle", {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    logic        id;
    logic [15:0] p;
    int          c;
    int          prev_c;
    int          lat;
    int          seen;
    n_vec = 0;
    n_err = 0;
    cyc   = 0;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    areset = 1'b1;
    #3;
    check_eq("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("rst_product", {16'd0, bus.rsp_product}, 32'd0);
    check_eq("rst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    repeat (2) @(negedge clk);
    areset = 1'b0;

    run_op(1'b0, 8'd255, 8'd1, 16'd255);
    run_op(1'b1, 8'd255, 8'd255, 16'd65025);
    run_op(1'b1, 8'd0, 8'd200, 16'd0);
    run_op(1'b0, 8'd13, 8'd11, 16'd143);

    // Operands and valids during BUSY must be ignored.
    @(negedge clk);
    bus.req1_valid = 1'b1; bus.req1_a = 8'd6; bus.req1_b = 8'd7;
    @(posedge clk);
    #1;
    bus.req1_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.req1_a = 8'd100; bus.req1_b = 8'd3;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    check_eq("ready0_busy", {31'd0, bus.req0_ready}, 32'd0);
    check_eq("ready1_busy", {31'd0, bus.req1_ready}, 32'd0);
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    wait_rsp(id, p, c, lat);
    check_eq("ignored_latency", lat, 32'd5);
    check_eq("ignored_id", {31'd0, id}, 32'd1);
    check_eq("ignored_product", {16'd0, p}, 32'd42);
    @(posedge clk);
    #1;

    // Reset mid-BUSY discards the operation.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd3;
    @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    areset = 1'b1;
    #1;
    check_eq("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("midrst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    check_eq("midrst_product", {16'd0, bus.rsp_product}, 32'd0);
    check_eq("midrst_rsp_id", {31'd0, bus.rsp_id}, 32'd0);
    @(negedge clk);
    areset = 1'b0;
    seen = 0;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk);
      #1;
      if (bus.rsp_valid) seen++;
    end
    check_eq("midrst_no_rsp", seen, 32'd0);
    check_eq("midrst_busy_after", {31'd0, bus.busy}, 32'd0);

    // Contention: both requesters held valid.
    @(negedge clk);
    bus.req0_valid = 1'b1; bus.req0_a = 8'd3; bus.req0_b = 8'd5;
    bus.req1_valid = 1'b1; bus.req1_a = 8'd7; bus.req1_b = 8'd9;
    #1;
    check_eq("cont_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check_eq("cont_ready1", {31'd0, bus.req1_ready}, 32'd0);
    prev_c = 0;
    for (int i = 0; i < 4; i++) begin
      wait_rsp(id, p, c, lat);
`ifdef MUL_ARB_ROUND_ROBIN_EN
      check_eq("cont_id", {31'd0, id}, (i % 2 == 1) ? 32'd1 : 32'd0);
      check_eq("cont_product", {16'd0, p}, (i % 2 == 1) ? 32'd63 : 32'd15);
`else
      check_eq("cont_id", {31'd0, id}, 32'd0);
      check_eq("cont_product", {16'd0, p}, 32'd15);
`endif
      if (i > 0) check_eq("cont_spacing", c - prev_c, 32'd10);
      prev_c = c;
    end
    bus.req0_valid = 1'b0;
    wait_rsp(id, p, c, lat);
    check_eq("drop_id", {31'd0, id}, 32'd1);
    check_eq("drop_product", {16'd0, p}, 32'd63);
    check_eq("drop_spacing", c - prev_c, 32'd10);
    bus.req1_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("final_busy", {31'd0, bus.busy}, 32'd0);
    check_eq("final_product_hold", {16'd0, bus.rsp_product}, 32'd63);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
